// File: rtl/spi_regbank_pkg.sv
// ---------------------------------------------------------------------------
// spi_regbank_pkg
// Shared definitions for the SPI command register bank:
//   - state_e          : command FSM states (IDLE, ARMED_WR, ARMED_RD)
//   - BAD_RD_VAL_DFLT  : default word returned for reads of unmapped addresses
//   - rw_bit_idx       : position of the R/W flag inside the command byte
//   - in_rw_region /
//     in_ro_region     : address-region compares for the control / status windows
// ---------------------------------------------------------------------------
package spi_regbank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMED_WR = 2'd1,
    ST_ARMED_RD = 2'd2
  } state_e;

  localparam logic [15:0] BAD_RD_VAL_DFLT = 16'hDEAD;

  // The R/W flag is the MSB of the command byte; the rest is the address.
  function automatic int rw_bit_idx(input int width_cmd);
    return width_cmd - 1;
  endfunction

  function automatic logic in_rw_region(input logic [31:0] addr,
                                        input logic [31:0] n_rw);
    return addr < n_rw;
  endfunction

  function automatic logic in_ro_region(input logic [31:0] addr,
                                        input logic [31:0] n_rw,
                                        input logic [31:0] n_ro);
    return (addr >= n_rw) && (addr < (n_rw + n_ro));
  endfunction

endpackage

// File: rtl/spi_cmd_regbank_if.sv
// ---------------------------------------------------------------------------
// spi_cmd_regbank_if
// Link between the SPI slave front-end and the command register bank.
//   done_cmd  : 1-cycle pulse, command frame complete (Dcmd valid)
//   Dcmd      : received command byte {rw, addr}
//   done_data : 1-cycle pulse, data frame complete (Dout valid)
//   Dout      : received data word
//   Din       : word the front-end transmits on the next data frame
// Modports: master = front-end side, slave = register bank side.
// ---------------------------------------------------------------------------
interface spi_cmd_regbank_if #(
  parameter int WIDTH_CMD  = 8,
  parameter int WIDTH_DATA = 16
);

  logic                  done_cmd;
  logic [WIDTH_CMD-1:0]  Dcmd;
  logic                  done_data;
  logic [WIDTH_DATA-1:0] Dout;
  logic [WIDTH_DATA-1:0] Din;

  modport master (
    output done_cmd, Dcmd, done_data, Dout,
    input  Din
  );

  modport slave (
    input  done_cmd, Dcmd, done_data, Dout,
    output Din
  );

endinterface

// File: rtl/spi_regbank_file.sv
// ---------------------------------------------------------------------------
// spi_regbank_file
// N_RW read/write control registers with one synchronous write port and one
// combinational read port.
//   clk, rst   : clock, synchronous active-high reset (regs -> RW_RST_VAL)
//   we         : write enable; waddr/wdata select the register and value
//   raddr      : combinational read address; rdata is '0 when out of range
//   ctrl_regs  : all registers flattened, reg k at [k*WIDTH_DATA +: WIDTH_DATA]
// ---------------------------------------------------------------------------
module spi_regbank_file
  import spi_regbank_pkg::*;
#(
  parameter int                    WIDTH_DATA = 16,
  parameter int                    N_RW       = 8,
  parameter int                    AW         = 7,
  parameter logic [WIDTH_DATA-1:0] RW_RST_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [AW-1:0]              waddr,
  input  logic [WIDTH_DATA-1:0]      wdata,
  input  logic [AW-1:0]              raddr,
  output logic [WIDTH_DATA-1:0]      rdata,
  output logic [N_RW*WIDTH_DATA-1:0] ctrl_regs
);

  logic [WIDTH_DATA-1:0] regs_q [N_RW];
  logic [WIDTH_DATA-1:0] regs_d [N_RW];

  always_comb begin
    regs_d = regs_q;
    for (int k = 0; k < N_RW; k++) begin
      if (we && in_rw_region(32'(waddr), 32'(N_RW)) && (32'(waddr) == 32'(k))) begin
        regs_d[k] = wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_RW; k++) begin
        regs_q[k] <= RW_RST_VAL;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rdata = '0;
    for (int k = 0; k < N_RW; k++) begin
      if (32'(raddr) == 32'(k)) begin
        rdata = regs_q[k];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < N_RW; k++) begin
      ctrl_regs[k*WIDTH_DATA +: WIDTH_DATA] = regs_q[k];
    end
  end

endmodule

// File: rtl/spi_cmd_regbank.sv
// ---------------------------------------------------------------------------
// spi_cmd_regbank
// Decodes SPI command/data frames from the slave front-end into accesses to a
// bank of control registers (read/write) and a window of status words
// (read-only), and supplies the word to shift out on the next data frame.
//   clk, rst   : clock, synchronous active-high reset
//   bus        : spi_cmd_regbank_if.slave (done_cmd, Dcmd, done_data, Dout, Din)
//   ctrl_regs  : flattened control registers, reg k at [k*WIDTH_DATA +: WIDTH_DATA]
//   status_in  : flattened status words from the fabric
//   wr_strobe  : 1-cycle pulse when a control register is written
//   wr_addr    : address of the last write, valid with wr_strobe
//   err        : 1-cycle pulse on a protocol or address error
// Optional feature, macro SPI_REGBANK_AUTO_INC_EN: burst access. Each data
// frame advances the latched address and the bank stays armed until a new
// command or a (silent) timeout. Undefined: one access per command.
// ---------------------------------------------------------------------------
module spi_cmd_regbank
  import spi_regbank_pkg::*;
#(
  parameter int                    WIDTH_CMD   = 8,
  parameter int                    WIDTH_DATA  = 16,
  parameter int                    N_RW        = 8,
  parameter int                    N_RO        = 4,
  parameter logic [WIDTH_DATA-1:0] RW_RST_VAL  = '0,
  parameter logic [WIDTH_DATA-1:0] BAD_RD_VAL  = WIDTH_DATA'(BAD_RD_VAL_DFLT),
  parameter int                    TIMEOUT_CYC = 65535
) (
  input  logic                       clk,
  input  logic                       rst,
  spi_cmd_regbank_if.slave           bus,
  output logic [N_RW*WIDTH_DATA-1:0] ctrl_regs,
  input  logic [N_RO*WIDTH_DATA-1:0] status_in,
  output logic                       wr_strobe,
  output logic [WIDTH_CMD-2:0]       wr_addr,
  output logic                       err
);

  localparam int RW_BIT = rw_bit_idx(WIDTH_CMD);
  localparam int AW     = WIDTH_CMD - 1;
  localparam int CNT_W  = $clog2(TIMEOUT_CYC + 1);

  state_e                state_q, state_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  served_q, served_d;
  logic [WIDTH_DATA-1:0] din_q, din_d;
  logic                  wr_strobe_q, wr_strobe_d;
  logic [AW-1:0]         wr_addr_q, wr_addr_d;
  logic                  err_q, err_d;

  logic                  cmd_rw;
  logic [AW-1:0]         cmd_addr;
  logic                  err_ctl;
  logic                  rd_err;
  logic                  we;
  logic                  rd_en;
  logic [AW-1:0]         raddr;
  logic [WIDTH_DATA-1:0] rf_rdata;
  logic [WIDTH_DATA-1:0] rd_word;
  logic [WIDTH_DATA-1:0] st_word;

  assign cmd_rw   = bus.Dcmd[RW_BIT];
  assign cmd_addr = bus.Dcmd[RW_BIT-1:0];

  spi_regbank_file #(
    .WIDTH_DATA (WIDTH_DATA),
    .N_RW       (N_RW),
    .AW         (AW),
    .RW_RST_VAL (RW_RST_VAL)
  ) u_file (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .waddr     (addr_q),
    .wdata     (bus.Dout),
    .raddr     (raddr),
    .rdata     (rf_rdata),
    .ctrl_regs (ctrl_regs)
  );

  // Control: the data frame is resolved against the current state first,
  // then a command in the same cycle is decoded on top of the result.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    served_d    = served_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    err_ctl     = 1'b0;
    we          = 1'b0;
    rd_en       = 1'b0;
    raddr       = addr_q;

    if (state_q != ST_IDLE) begin
      cnt_d = cnt_q + 1'b1;
    end

    if (bus.done_data) begin
      case (state_q)
        ST_ARMED_WR: begin
          if (in_rw_region(32'(addr_q), 32'(N_RW))) begin
            we          = 1'b1;
            wr_strobe_d = 1'b1;
            wr_addr_d   = addr_q;
          end else begin
            err_ctl = 1'b1;
          end
`ifdef SPI_REGBANK_AUTO_INC_EN
          addr_d   = addr_q + 1'b1;
          served_d = 1'b1;
          cnt_d    = '0;
`else
          state_d  = ST_IDLE;
          cnt_d    = '0;
`endif
        end
        ST_ARMED_RD: begin
`ifdef SPI_REGBANK_AUTO_INC_EN
          addr_d   = addr_q + 1'b1;
          served_d = 1'b1;
          cnt_d    = '0;
          rd_en    = 1'b1;
          raddr    = addr_q + 1'b1;
`else
          state_d  = ST_IDLE;
          cnt_d    = '0;
`endif
        end
        default: err_ctl = 1'b1;  // data frame with no command armed
      endcase
    end else if ((state_q != ST_IDLE) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1))) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
`ifdef SPI_REGBANK_AUTO_INC_EN
      // Timeout is the normal end of a burst, so it is not an error.
`else
      err_ctl = 1'b1;
`endif
    end

    if (bus.done_cmd) begin
      // A command still armed here never saw its data frame: it is abandoned.
      if ((state_d != ST_IDLE) && !served_d) begin
        err_ctl = 1'b1;
      end
      addr_d   = cmd_addr;
      cnt_d    = '0;
      served_d = 1'b0;
      if (cmd_rw) begin
        state_d = ST_ARMED_WR;
      end else begin
        state_d = ST_ARMED_RD;
        rd_en   = 1'b1;
        raddr   = cmd_addr;
      end
    end
  end

  // A write and a read of the same register in one cycle returns the new
  // value, matching the data-then-command ordering above.
  assign rd_word = (we && (raddr == addr_q)) ? bus.Dout : rf_rdata;

  // Read source selection; the status word is captured once, here.
  always_comb begin
    din_d   = din_q;
    rd_err  = 1'b0;
    st_word = '0;
    for (int k = 0; k < N_RO; k++) begin
      if (32'(raddr) == 32'(N_RW + k)) begin
        st_word = status_in[k*WIDTH_DATA +: WIDTH_DATA];
      end
    end
    if (rd_en) begin
      if (in_rw_region(32'(raddr), 32'(N_RW))) begin
        din_d = rd_word;
      end else if (in_ro_region(32'(raddr), 32'(N_RW), 32'(N_RO))) begin
        din_d = st_word;
      end else begin
        din_d  = BAD_RD_VAL;
        rd_err = 1'b1;
      end
    end
  end

  // All error causes of one cycle merge into a single pulse.
  assign err_d = err_ctl | rd_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      served_q    <= 1'b0;
      din_q       <= '0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      served_q    <= served_d;
      din_q       <= din_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      err_q       <= err_d;
    end
  end

  assign bus.Din   = din_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign err       = err_q;

endmodule

// File: tb/tb_spi_cmd_regbank.sv
// ---------------------------------------------------------------------------
// tb_spi_cmd_regbank
// Self-checking bench for spi_cmd_regbank (TIMEOUT_CYC = 100). A transaction
// level reference model (register array, armed flag, latched address) tracks
// expected register contents, Din, and error / write pulse counts.
// Honours SPI_REGBANK_AUTO_INC_EN when defined.
// ---------------------------------------------------------------------------
module tb_spi_cmd_regbank;

  localparam int WC  = 8;
  localparam int WD  = 16;
  localparam int NRW = 8;
  localparam int NRO = 4;
  localparam int TO  = 100;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NRW*WD-1:0]   ctrl_regs;
  logic [NRO*WD-1:0]   status_in = '0;
  logic                wr_strobe;
  logic [WC-2:0]       wr_addr;
  logic                err;

  spi_cmd_regbank_if #(.WIDTH_CMD(WC), .WIDTH_DATA(WD)) bus ();

  spi_cmd_regbank #(
    .WIDTH_CMD   (WC),
    .WIDTH_DATA  (WD),
    .N_RW        (NRW),
    .N_RO        (NRO),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .ctrl_regs (ctrl_regs),
    .status_in (status_in),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .err       (err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Pulse counters sampled on the falling edge.
  int         err_seen = 0;
  int         wr_seen  = 0;
  logic [6:0] last_wr_addr = '0;
  always @(negedge clk) begin
    if (err === 1'b1) err_seen++;
    if (wr_strobe === 1'b1) begin
      wr_seen++;
      last_wr_addr = wr_addr;
    end
  end

  // Reference model
  logic [15:0] m_regs [NRW];
  logic [15:0] m_din;
  bit          m_armed, m_write, m_served;
  int          m_addr;
  int          exp_err = 0;
  int          exp_wr  = 0;

  function automatic logic [15:0] m_word(input int a);
    if (a < NRW) return m_regs[a];
    if (a < NRW + NRO) return status_in[(a-NRW)*WD +: WD];
    return 16'hDEAD;
  endfunction

  function automatic logic [NRW*WD-1:0] m_flat();
    logic [NRW*WD-1:0] f;
    for (int k = 0; k < NRW; k++) f[k*WD +: WD] = m_regs[k];
    return f;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < NRW; k++) m_regs[k] = 16'h0;
    m_din = 16'h0; m_armed = 0; m_write = 0; m_served = 0; m_addr = 0;
  endtask

  task automatic m_cycle(input bit hc, input logic [7:0] c, input bit hd, input logic [15:0] d);
    bit e = 0;
    if (hd) begin
      if (!m_armed) e = 1;
      else begin
        if (m_write) begin
          if (m_addr < NRW) begin m_regs[m_addr] = d; exp_wr++; end
          else e = 1;
        end
`ifdef SPI_REGBANK_AUTO_INC_EN
        m_addr = (m_addr + 1) % 128;
        m_served = 1;
        if (!m_write) begin
          m_din = m_word(m_addr);
          if (m_addr >= NRW + NRO) e = 1;
        end
`else
        m_armed = 0;
`endif
      end
    end
    if (hc) begin
      if (m_armed && !m_served) e = 1;
      m_armed = 1; m_write = c[7]; m_addr = int'(c[6:0]); m_served = 0;
      if (!m_write) begin
        m_din = m_word(m_addr);
        if (m_addr >= NRW + NRO) e = 1;
      end
    end
    if (e) exp_err++;
  endtask

  // One clock of stimulus, model updated with the same inputs.
  task automatic drive_cycle(input bit hc, input logic [7:0] c, input bit hd, input logic [15:0] d);
    bus.done_cmd = hc; bus.Dcmd = c; bus.done_data = hd; bus.Dout = d;
    m_cycle(hc, c, hd, d);
    @(negedge clk); #1;
    bus.done_cmd = 1'b0; bus.done_data = 1'b0;
  endtask

  task automatic go_idle();
    rst = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    rst = 1'b0;
    m_reset();
  endtask

  task automatic test_reset();
    bus.done_cmd = 0; bus.Dcmd = '0; bus.done_data = 0; bus.Dout = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (bus.Din !== 16'h0) begin failures++; $display("FAIL reset_din got=%h exp=0000", bus.Din); end
    checks++; if (ctrl_regs !== '0) begin failures++; $display("FAIL reset_regs got=%h exp=0", ctrl_regs); end
    checks++; if (wr_strobe !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL reset_pulses wr=%b err=%b exp=0/0", wr_strobe, err); end
    checks++; if (wr_addr !== 7'h0) begin failures++; $display("FAIL reset_wr_addr got=%h exp=00", wr_addr); end
    rst = 1'b0;
    m_reset();
    err_seen = 0; wr_seen = 0; exp_err = 0; exp_wr = 0;
  endtask

  task automatic test_write();
    int e0, w0;
    go_idle();
    e0 = err_seen; w0 = wr_seen;
    drive_cycle(1, 8'h83, 0, 16'h0);
    drive_cycle(0, 8'h00, 1, 16'h1234);
    checks++; if (wr_strobe !== 1'b1 || wr_addr !== 7'd3) begin failures++; $display("FAIL write_strobe wr=%b addr=%0d exp=1/3", wr_strobe, wr_addr); end
    checks++; if (ctrl_regs[3*WD +: WD] !== 16'h1234) begin failures++; $display("FAIL write_reg3 got=%h exp=1234", ctrl_regs[3*WD +: WD]); end
    drive_cycle(0, 8'h00, 0, 16'h0);
    checks++; if (wr_strobe !== 1'b0 || wr_seen != w0 + 1) begin failures++; $display("FAIL write_pulse_width wr=%b count=%0d exp=0/%0d", wr_strobe, wr_seen, w0 + 1); end
    checks++; if (err_seen != e0) begin failures++; $display("FAIL write_no_err got=%0d exp=%0d", err_seen, e0); end
    checks++; if (ctrl_regs !== m_flat()) begin failures++; $display("FAIL write_regs got=%h exp=%h", ctrl_regs, m_flat()); end
  endtask

  task automatic test_read_status();
    go_idle();
    status_in[1*WD +: WD] = 16'hBEEF;
    drive_cycle(1, 8'h09, 0, 16'h0);
    checks++; if (bus.Din !== 16'hBEEF) begin failures++; $display("FAIL read_status got=%h exp=beef", bus.Din); end
    status_in[1*WD +: WD] = 16'h1111;
    repeat (3) drive_cycle(0, 8'h00, 0, 16'h0);
    checks++; if (bus.Din !== 16'hBEEF) begin failures++; $display("FAIL read_status_hold got=%h exp=beef", bus.Din); end
    status_in[2*WD +: WD] = 16'h2222;
    drive_cycle(0, 8'h00, 1, 16'h5A5A);
    checks++; if (bus.Din !== m_din) begin failures++; $display("FAIL read_close_din got=%h exp=%h", bus.Din, m_din); end
    checks++; if (err_seen != exp_err) begin failures++; $display("FAIL read_close_err got=%0d exp=%0d", err_seen, exp_err); end
  endtask

  task automatic test_unmapped();
    int e0, w0;
    go_idle();
    e0 = err_seen; w0 = wr_seen;
    drive_cycle(1, 8'h7F, 0, 16'h0);
    drive_cycle(0, 8'h00, 0, 16'h0);
    checks++; if (bus.Din !== 16'hDEAD) begin failures++; $display("FAIL unmapped_rd_din got=%h exp=dead", bus.Din); end
    checks++; if (err_seen != e0 + 1) begin failures++; $display("FAIL unmapped_rd_err got=%0d exp=%0d", err_seen, e0 + 1); end
    drive_cycle(0, 8'h00, 1, 16'h0);
    drive_cycle(1, 8'hFF, 0, 16'h0);
    drive_cycle(0, 8'h00, 1, 16'h4321);
    drive_cycle(0, 8'h00, 0, 16'h0);
    checks++; if (wr_seen != w0) begin failures++; $display("FAIL unmapped_wr_strobe got=%0d exp=%0d", wr_seen, w0); end
    checks++; if (err_seen != e0 + 2) begin failures++; $display("FAIL unmapped_wr_err got=%0d exp=%0d", err_seen, e0 + 2); end
    checks++; if (ctrl_regs !== '0) begin failures++; $display("FAIL unmapped_wr_regs got=%h exp=0", ctrl_regs); end
  endtask

  task automatic test_sequencing();
    int e0;
    go_idle();
    e0 = err_seen;
    drive_cycle(0, 8'h00, 1, 16'hFFFF);
    checks++; if (err_seen != e0 + 1 || ctrl_regs !== '0) begin failures++; $display("FAIL idle_data err=%0d regs=%h exp=%0d/0", err_seen, ctrl_regs, e0 + 1); end
    drive_cycle(1, 8'h82, 0, 16'h0);
    drive_cycle(1, 8'h84, 0, 16'h0);
    drive_cycle(0, 8'h00, 1, 16'h00AA);
    checks++; if (ctrl_regs[4*WD +: WD] !== 16'h00AA || ctrl_regs[2*WD +: WD] !== 16'h0) begin failures++; $display("FAIL replace_cmd reg4=%h reg2=%h exp=00aa/0000", ctrl_regs[4*WD +: WD], ctrl_regs[2*WD +: WD]); end
    checks++; if (err_seen != e0 + 2) begin failures++; $display("FAIL replace_cmd_err got=%0d exp=%0d", err_seen, e0 + 2); end
  endtask

  task automatic test_same_cycle();
    int e0;
    go_idle();
    drive_cycle(1, 8'h81, 0, 16'h0);
    drive_cycle(0, 8'h00, 1, 16'h7777);
    e0 = err_seen;
    drive_cycle(1, 8'h85, 0, 16'h0);
    drive_cycle(1, 8'h01, 1, 16'h5555);
    checks++; if (ctrl_regs[5*WD +: WD] !== 16'h5555) begin failures++; $display("FAIL same_cycle_reg5 got=%h exp=5555", ctrl_regs[5*WD +: WD]); end
    checks++; if (bus.Din !== 16'h7777) begin failures++; $display("FAIL same_cycle_din got=%h exp=7777", bus.Din); end
    checks++; if (err_seen != e0 || err_seen != exp_err) begin failures++; $display("FAIL same_cycle_err got=%0d exp=%0d", err_seen, e0); end
  endtask

  task automatic test_timeout();
    int e0, n;
    bit seen;
    go_idle();
    drive_cycle(1, 8'h81, 0, 16'h0);
    e0 = err_seen; seen = 0; n = 0;
`ifdef SPI_REGBANK_AUTO_INC_EN
    repeat (TO + 20) begin
      @(negedge clk); #1;
      if (err_seen != e0) seen = 1;
    end
    checks++; if (seen) begin failures++; $display("FAIL timeout_silent err pulses=%0d exp=0", err_seen - e0); end
`else
    while (!seen && n < 3*TO) begin
      @(negedge clk); #1;
      n++;
      if (err_seen != e0) seen = 1;
    end
    checks++; if (!seen || n < TO - 1 || n > TO + 1) begin failures++; $display("FAIL timeout_err seen=%0d cycle=%0d exp=1/%0d", seen, n, TO); end
    exp_err++;
`endif
    m_armed = 0;
    drive_cycle(0, 8'h00, 1, 16'hABCD);
    checks++; if (err_seen != exp_err) begin failures++; $display("FAIL timeout_then_data_err got=%0d exp=%0d", err_seen, exp_err); end
    checks++; if (ctrl_regs[1*WD +: WD] !== 16'h0) begin failures++; $display("FAIL timeout_reg1 got=%h exp=0000", ctrl_regs[1*WD +: WD]); end
  endtask

  task automatic test_reset_mid();
    int e0, w0;
    go_idle();
    drive_cycle(1, 8'h80, 0, 16'h0);
    drive_cycle(0, 8'h00, 1, 16'h0F0F);
    drive_cycle(1, 8'h83, 0, 16'h0);
    e0 = err_seen; w0 = wr_seen;
    bus.done_data = 1'b1; bus.Dout = 16'h55AA; rst = 1'b1;
    @(negedge clk); #1;
    bus.done_data = 1'b0;
    @(negedge clk); #1;
    rst = 1'b0;
    m_reset();
    drive_cycle(0, 8'h00, 0, 16'h0);
    checks++; if (ctrl_regs !== '0 || bus.Din !== 16'h0) begin failures++; $display("FAIL reset_mid_state regs=%h din=%h exp=0/0", ctrl_regs, bus.Din); end
    checks++; if (wr_seen != w0 || err_seen != e0) begin failures++; $display("FAIL reset_mid_pulses wr=%0d err=%0d exp=%0d/%0d", wr_seen, err_seen, w0, e0); end
    exp_err = err_seen; exp_wr = wr_seen;
  endtask

`ifdef SPI_REGBANK_AUTO_INC_EN
  task automatic test_autoinc();
    int e0, w0;
    go_idle();
    e0 = err_seen; w0 = wr_seen;
    drive_cycle(1, 8'h86, 0, 16'h0);
    drive_cycle(0, 8'h00, 1, 16'h0001);
    drive_cycle(0, 8'h00, 1, 16'h0002);
    drive_cycle(0, 8'h00, 0, 16'h0);
    checks++; if (ctrl_regs[6*WD +: WD] !== 16'h1 || ctrl_regs[7*WD +: WD] !== 16'h2) begin failures++; $display("FAIL burst_regs reg6=%h reg7=%h exp=0001/0002", ctrl_regs[6*WD +: WD], ctrl_regs[7*WD +: WD]); end
    checks++; if (wr_seen != w0 + 2 || last_wr_addr !== 7'd7 || err_seen != e0) begin failures++; $display("FAIL burst_strobes wr=%0d addr=%0d err=%0d exp=%0d/7/%0d", wr_seen, last_wr_addr, err_seen, w0 + 2, e0); end
    drive_cycle(1, 8'h06, 0, 16'h0);
    checks++; if (bus.Din !== 16'h1) begin failures++; $display("FAIL burst_rd0 got=%h exp=0001", bus.Din); end
    drive_cycle(0, 8'h00, 1, 16'h0);
    checks++; if (bus.Din !== 16'h2) begin failures++; $display("FAIL burst_rd1 got=%h exp=0002", bus.Din); end
    drive_cycle(1, 8'h82, 0, 16'h0);
    drive_cycle(0, 8'h00, 1, 16'h0033);
    rst = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    rst = 1'b0;
    m_reset();
    drive_cycle(0, 8'h00, 1, 16'h0044);
    checks++; if (ctrl_regs !== '0) begin failures++; $display("FAIL burst_reset_regs got=%h exp=0", ctrl_regs); end
    checks++; if (err_seen != e0 + 1) begin failures++; $display("FAIL burst_reset_idle err=%0d exp=%0d", err_seen, e0 + 1); end
    exp_err = err_seen; exp_wr = wr_seen;
  endtask
`endif

  task automatic test_random();
    int kind;
    logic [7:0]  c;
    logic [15:0] d;
    go_idle();
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 7) == 0)
        status_in[$urandom_range(0, NRO-1)*WD +: WD] = 16'($urandom);
      kind = $urandom_range(0, 4);
      c[7]   = 1'($urandom);
      c[6:0] = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(12, 127)) : 7'($urandom_range(0, 11));
      d      = 16'($urandom);
      drive_cycle(kind == 1 || kind == 3, c, kind >= 2, d);
      checks++; if (bus.Din !== m_din) begin failures++; $display("FAIL rand_din i=%0d got=%h exp=%h", i, bus.Din, m_din); end
      checks++; if (ctrl_regs !== m_flat()) begin failures++; $display("FAIL rand_regs i=%0d got=%h exp=%h", i, ctrl_regs, m_flat()); end
      checks++; if (err_seen != exp_err) begin failures++; $display("FAIL rand_err i=%0d got=%0d exp=%0d", i, err_seen, exp_err); end
      checks++; if (wr_seen != exp_wr) begin failures++; $display("FAIL rand_wr i=%0d got=%0d exp=%0d", i, wr_seen, exp_wr); end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_status();
    test_unmapped();
    test_sequencing();
    test_same_cycle();
    test_timeout();
    test_reset_mid();
`ifdef SPI_REGBANK_AUTO_INC_EN
    test_autoinc();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
